// File: rtl/a2d_sweep_seq_pkg.sv
// a2d_seq_pkg: shared types, widths and the smoothing step for the A2D
// sweep sequencer.
//   state_t   sweep FSM states (IDLE, START, WAIT)
//   RES_W     conversion result width
//   CH_W      channel select width
//   avg_step  one first-order smoothing update of a stored average
package a2d_seq_pkg;

  localparam int RES_W = 12;
  localparam int CH_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // avg + ((smp - avg) >>> shift), computed in 13-bit signed arithmetic.
  // The arithmetic shift floors toward minus infinity, so a falling input
  // never overshoots below the new sample and the sum stays in 0..4095.
  function automatic logic [RES_W-1:0] avg_step(
    input logic [RES_W-1:0] avg,
    input logic [RES_W-1:0] smp,
    input int               shift
  );
    logic signed [RES_W:0] diff;
    logic signed [RES_W:0] sum;
    diff = $signed({1'b0, smp}) - $signed({1'b0, avg});
    sum  = $signed({1'b0, avg}) + (diff >>> shift);
    return sum[RES_W-1:0];
  endfunction

endpackage

// File: rtl/a2d_sweep_seq_if.sv
// a2d_sweep_seq_if: conversion handshake between the sweep sequencer and
// the A2D SPI interface.
//   strt_cnv   one-cycle conversion request
//   chnnl      channel of the pending request
//   cnv_cmplt  one-cycle completion pulse
//   res        conversion result, valid with cnv_cmplt
// Modports: master = sequencer side, slave = A2D side.
interface a2d_sweep_seq_if;
  import a2d_seq_pkg::*;

  logic             strt_cnv;
  logic [CH_W-1:0]  chnnl;
  logic             cnv_cmplt;
  logic [RES_W-1:0] res;

  modport master (
    output strt_cnv,
    output chnnl,
    input  cnv_cmplt,
    input  res
  );

  modport slave (
    input  strt_cnv,
    input  chnnl,
    output cnv_cmplt,
    output res
  );

endinterface

// File: rtl/a2d_sweep_seq_tmr.sv
// a2d_seq_tmr: free-running sweep period counter.
//   clk   system clock
//   rst   asynchronous active-high reset (count returns to 0)
//   tick  high in the cycle the count equals PERIOD-1; count wraps next cycle
module a2d_seq_tmr #(
  parameter int PERIOD = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: wrap after the terminal value.
  always_comb begin
    if (cnt_q == LAST) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/a2d_sweep_seq.sv
// a2d_sweep_seq: round-robin sensor sweeper in front of the A2D interface.
// On each period tick (while en) it converts channels 0..N_CH-1 in turn,
// keeps a raw and a smoothed value per channel, and serves them on a
// random-access read port. A conversion that never completes within TMO
// wait cycles aborts the sweep and sets a sticky error.
//   clk, rst    clock, asynchronous active-high reset
//   en          allows new sweeps to start
//   a2d         conversion handshake (master side)
//   rd_ch       read channel select
//   rd_raw      last raw sample of rd_ch (0 when rd_ch >= N_CH)
//   rd_avg      smoothed value of rd_ch (0 when rd_ch >= N_CH)
//   all_vld     every swept channel holds at least one sample
//   sweep_done  one-cycle pulse after the last channel of a sweep
//   tmo_err     sticky conversion timeout flag
module a2d_sweep_seq
  import a2d_seq_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int PERIOD = 50000,
  parameter int SHIFT  = 2,
  parameter int TMO    = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  a2d_sweep_seq_if.master  a2d,
  input  logic [CH_W-1:0]  rd_ch,
  output logic [RES_W-1:0] rd_raw,
  output logic [RES_W-1:0] rd_avg,
  output logic             all_vld,
  output logic             sweep_done,
  output logic             tmo_err
);

  localparam int WCNT_W = $clog2(TMO + 1);
  // The counter is cleared in START and is 0 in the first WAIT cycle, so
  // the TMO-th WAIT cycle sees TMO-1 and is the one that aborts.
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TMO - 1);
  localparam logic [CH_W-1:0]   LAST_IDX  = CH_W'(N_CH - 1);

  logic tick;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   idx_q, idx_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              strt_cnv_q, strt_cnv_d;
  logic [CH_W-1:0]   chnnl_q, chnnl_d;
  logic              sweep_done_q, sweep_done_d;
  logic              tmo_err_q, tmo_err_d;
  logic              cap;

  logic [RES_W-1:0]  raw_q [N_CH];
  logic [RES_W-1:0]  raw_d [N_CH];
  logic [RES_W-1:0]  avg_q [N_CH];
  logic [RES_W-1:0]  avg_d [N_CH];
  logic [N_CH-1:0]   vld_q, vld_d;
  logic [N_CH-1:0]   wr_sel;

  a2d_seq_tmr #(
    .PERIOD (PERIOD)
  ) u_tmr (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Sweep FSM: next state, channel index, wait counter and output pulses.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wcnt_d       = wcnt_q;
    strt_cnv_d   = 1'b0;
    chnnl_d      = chnnl_q;
    sweep_done_d = 1'b0;
    tmo_err_d    = tmo_err_q;
    cap          = 1'b0;
    case (state_q)
      IDLE: begin
        // Ticks are only honoured here, so a tick during a sweep is lost.
        if (tick && en) begin
          state_d    = START;
          idx_d      = {CH_W{1'b0}};
          chnnl_d    = {CH_W{1'b0}};
          strt_cnv_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        state_d = WAIT;
        wcnt_d  = {WCNT_W{1'b0}};
      end
      WAIT: begin
        wcnt_d = wcnt_q + WCNT_W'(1);
        // Completion is tested first so it wins over a same-cycle timeout.
        if (a2d.cnv_cmplt) begin
          cap = 1'b1;
          if (idx_q == LAST_IDX) begin
            sweep_done_d = 1'b1;
            state_d      = IDLE;
          end else begin
            idx_d      = idx_q + CH_W'(1);
            chnnl_d    = idx_q + CH_W'(1);
            strt_cnv_d = 1'b1;
            state_d    = START;
          end
        end else if (wcnt_q == WCNT_LAST) begin
          tmo_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // One-hot write select: the channel being captured this cycle.
  always_comb begin
    wr_sel = {N_CH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      wr_sel[i] = cap && (idx_q == CH_W'(i));
    end
  end

  // Per-channel storage update; first sample loads the average directly.
  always_comb begin
    vld_d = vld_q | wr_sel;
    for (int i = 0; i < N_CH; i++) begin
      raw_d[i] = wr_sel[i] ? a2d.res : raw_q[i];
      avg_d[i] = !wr_sel[i] ? avg_q[i] :
                 (vld_q[i] ? avg_step(avg_q[i], a2d.res, SHIFT) : a2d.res);
    end
  end

  // Read port: AND-OR mux; an out-of-range rd_ch selects nothing and reads 0.
  always_comb begin
    rd_raw = {RES_W{1'b0}};
    rd_avg = {RES_W{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      rd_raw = rd_raw | ({RES_W{rd_ch == CH_W'(i)}} & raw_q[i]);
      rd_avg = rd_avg | ({RES_W{rd_ch == CH_W'(i)}} & avg_q[i]);
    end
  end

  // FSM and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= {CH_W{1'b0}};
      wcnt_q       <= {WCNT_W{1'b0}};
      strt_cnv_q   <= 1'b0;
      chnnl_q      <= {CH_W{1'b0}};
      sweep_done_q <= 1'b0;
      tmo_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wcnt_q       <= wcnt_d;
      strt_cnv_q   <= strt_cnv_d;
      chnnl_q      <= chnnl_d;
      sweep_done_q <= sweep_done_d;
      tmo_err_q    <= tmo_err_d;
    end
  end

  // Per-channel sample storage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= {N_CH{1'b0}};
      for (int i = 0; i < N_CH; i++) begin
        raw_q[i] <= {RES_W{1'b0}};
        avg_q[i] <= {RES_W{1'b0}};
      end
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < N_CH; i++) begin
        raw_q[i] <= raw_d[i];
        avg_q[i] <= avg_d[i];
      end
    end
  end

  assign a2d.strt_cnv = strt_cnv_q;
  assign a2d.chnnl    = chnnl_q;
  assign sweep_done   = sweep_done_q;
  assign tmo_err      = tmo_err_q;
  assign all_vld      = &vld_q;

endmodule
